// File: rtl/charmatrix_stream.sv
// Character-matrix text buffer with byte write port, tear-free shadow copy and a
// per-frame pixel streamer that feeds a ws2812b driver via valid/ready/latch.
module charmatrix_stream #(
  parameter int          NUM_CHARS    = 4,
  parameter int          CHAR_W       = 5,
  parameter int          CHAR_H       = 7,
  parameter int          REFRESH_BITS = 16,
  parameter int          COLOR_BITS   = 4,
  parameter logic [7:0]  CLEAR_CODE   = 8'h0C
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  input  logic [COLOR_BITS-1:0]    rx_color,
  input  logic                     scroll_en,
  output logic [7:0]               rom_char,
  input  logic [CHAR_W*CHAR_H-1:0] rom_glyph,
  output logic [COLOR_BITS-1:0]    pal_index,
  input  logic [23:0]              pal_rgb,
  output logic [23:0]              px_data,
  output logic                     px_valid,
  output logic                     px_latch,
  input  logic                     px_ready,
  output logic                     frame_busy
);

  localparam int GLYPH_PX = CHAR_W * CHAR_H;
  localparam int TOTAL_PX = NUM_CHARS * GLYPH_PX;
  localparam int PCW      = $clog2(TOTAL_PX + 1);
  localparam int CHW      = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int BW       = (GLYPH_PX > 1) ? $clog2(GLYPH_PX) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_READY, WAIT_ACCEPT} state_t;

  logic [7:0]              text_q         [NUM_CHARS];
  logic [COLOR_BITS-1:0]   color_q        [NUM_CHARS];
  logic [7:0]              shadow_text_q  [NUM_CHARS];
  logic [COLOR_BITS-1:0]   shadow_color_q [NUM_CHARS];
  logic [CHW-1:0]          ptr_q;
  logic                    rx_ready_q;
  logic [REFRESH_BITS-1:0] refresh_q;

  state_t           state_q, state_d;
  logic [CHW-1:0]   char_q, char_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [PCW-1:0]   px_cnt_q, px_cnt_d;
  logic [23:0]      px_data_q, px_data_d;
  logic             px_valid_q, px_valid_d;
  logic             px_latch_q, px_latch_d;
  logic             frame_busy_q, frame_busy_d;

  logic accept, is_clear, trigger, frame_start;

  assign accept      = rx_valid & rx_ready_q;
  assign is_clear    = (rx_data == CLEAR_CODE);
  assign trigger     = &refresh_q;
  assign frame_start = (state_q == IDLE) && trigger;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_ready_q <= 1'b0;
      refresh_q  <= '0;
      ptr_q      <= '0;
    end else begin
      rx_ready_q <= 1'b1;
      refresh_q  <= refresh_q + 1'b1;
      if (accept) begin
        if (is_clear)
          ptr_q <= '0;
        else if (!scroll_en)
          ptr_q <= (ptr_q == CHW'(NUM_CHARS - 1)) ? '0 : ptr_q + 1'b1;
      end
    end
  end

  // One slot per character; in scroll mode each slot takes its upper neighbour.
  for (genvar gi = 0; gi < NUM_CHARS; gi++) begin : g_entry
    logic [7:0]            up_text;
    logic [COLOR_BITS-1:0] up_color;

    if (gi == NUM_CHARS - 1) begin : g_top
      assign up_text  = rx_data;
      assign up_color = rx_color;
    end else begin : g_mid
      assign up_text  = text_q[gi+1];
      assign up_color = color_q[gi+1];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        text_q[gi]         <= 8'h20;
        color_q[gi]        <= COLOR_BITS'(gi);
        shadow_text_q[gi]  <= 8'h20;
        shadow_color_q[gi] <= COLOR_BITS'(gi);
      end else begin
        if (frame_start) begin
          shadow_text_q[gi]  <= text_q[gi];
          shadow_color_q[gi] <= color_q[gi];
        end
        if (accept) begin
          if (is_clear) begin
            text_q[gi] <= 8'h20;
          end else if (scroll_en) begin
            text_q[gi]  <= up_text;
            color_q[gi] <= up_color;
          end else if (ptr_q == CHW'(gi)) begin
            text_q[gi]  <= rx_data;
            color_q[gi] <= rx_color;
          end
        end
      end
    end
  end

  assign rom_char  = shadow_text_q[char_q];
  assign pal_index = shadow_color_q[char_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      char_q       <= '0;
      bit_q        <= '0;
      px_cnt_q     <= '0;
      px_data_q    <= '0;
      px_valid_q   <= 1'b0;
      px_latch_q   <= 1'b0;
      frame_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      char_q       <= char_d;
      bit_q        <= bit_d;
      px_cnt_q     <= px_cnt_d;
      px_data_q    <= px_data_d;
      px_valid_q   <= px_valid_d;
      px_latch_q   <= px_latch_d;
      frame_busy_q <= frame_busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    char_d       = char_q;
    bit_d        = bit_q;
    px_cnt_d     = px_cnt_q;
    px_data_d    = px_data_q;
    px_valid_d   = px_valid_q;
    px_latch_d   = px_latch_q;
    frame_busy_d = frame_busy_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d      = LOAD;
          frame_busy_d = 1'b1;
          char_d       = '0;
          bit_d        = '0;
          px_cnt_d     = '0;
        end
      end
      LOAD: begin
        px_data_d  = rom_glyph[bit_q] ? pal_rgb : 24'h0;
        px_latch_d = (px_cnt_q == PCW'(TOTAL_PX - 1));
        state_d    = WAIT_READY;
      end
      WAIT_READY: begin
        if (px_ready) begin
          px_valid_d = 1'b1;
          px_cnt_d   = px_cnt_q + 1'b1;
          if (bit_q == BW'(GLYPH_PX - 1)) begin
            bit_d  = '0;
            char_d = (char_q == CHW'(NUM_CHARS - 1)) ? '0 : char_q + 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
          state_d = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT: begin
        if (!px_ready) begin
          px_valid_d = 1'b0;
          if (px_cnt_q == PCW'(TOTAL_PX)) begin
            state_d      = IDLE;
            frame_busy_d = 1'b0;
            px_latch_d   = 1'b0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_ready   = rx_ready_q;
  assign px_data    = px_data_q;
  assign px_valid   = px_valid_q;
  assign px_latch   = px_latch_q;
  assign frame_busy = frame_busy_q;

endmodule

// File: tb/tb_charmatrix_stream.sv
// Bench for charmatrix_stream: ws2812b handshake model plus a pixel scoreboard fed
// with hand-written buffer contents rendered through the bench's glyph/palette ROMs.
module tb_charmatrix_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [3:0]  rx_color = 4'h0;
  logic        scroll_en = 1'b0;
  logic [7:0]  rom_char;
  logic [34:0] rom_glyph;
  logic [3:0]  pal_index;
  logic [23:0] pal_rgb;
  logic [23:0] px_data;
  logic        px_valid;
  logic        px_latch;
  logic        px_ready = 1'b1;
  logic        frame_busy;

  int checks = 0;
  int errors = 0;
  logic hold_low = 1'b0;
  int busy_cnt = 0;
  int pix_n = 0;
  logic [24:0] exp_q [$];

  always #25 clk = ~clk;

  charmatrix_stream #(
    .NUM_CHARS(4), .CHAR_W(5), .CHAR_H(7), .REFRESH_BITS(11),
    .COLOR_BITS(4), .CLEAR_CODE(8'h0C)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_color(rx_color), .scroll_en(scroll_en),
    .rom_char(rom_char), .rom_glyph(rom_glyph),
    .pal_index(pal_index), .pal_rgb(pal_rgb),
    .px_data(px_data), .px_valid(px_valid), .px_latch(px_latch),
    .px_ready(px_ready), .frame_busy(frame_busy)
  );

  function automatic logic [34:0] glyph_f(input logic [7:0] c);
    return {c[2:0], c, c ^ 8'h5A, c, ~c};
  endfunction

  function automatic logic [23:0] pal_f(input logic [3:0] i);
    return {i, 4'h5, ~i, 4'hA, i, i};
  endfunction

  assign rom_glyph = glyph_f(rom_char);
  assign pal_rgb   = pal_f(pal_index);

  // ws2812b model and scoreboard monitor
  always @(negedge clk) begin
    logic [24:0] e;
    if (!rst_n) begin
      px_ready = 1'b1;
      busy_cnt = 0;
    end else if (px_ready && px_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_extra[%0d] got data=%h latch=%b required no pixel", pix_n, px_data, px_latch);
      end else begin
        e = exp_q.pop_front();
        if ({px_data, px_latch} !== e) begin
          errors++;
          $display("FAIL pixel[%0d] got data=%h latch=%b required data=%h latch=%b",
                   pix_n, px_data, px_latch, e[24:1], e[0]);
        end else begin
          $display("px %0d data=%h latch=%b", pix_n, px_data, px_latch);
        end
      end
      pix_n++;
      px_ready = 1'b0;
      busy_cnt = 2;
    end else if (hold_low) begin
      px_ready = 1'b0;
    end else if (!px_ready) begin
      if (busy_cnt > 0) busy_cnt--;
      else if (!px_valid) px_ready = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end else begin
      $display("check %s = %h ok", name, got);
    end
  endtask

  // txt/col packed with character 0 in the low bits
  task automatic push_frame(input logic [31:0] txt, input logic [15:0] col);
    logic [7:0]  c;
    logic [3:0]  p;
    logic [34:0] g;
    logic [23:0] d;
    for (int i = 0; i < 4; i++) begin
      c = txt[i*8 +: 8];
      p = col[i*4 +: 4];
      g = glyph_f(c);
      for (int b = 0; b < 35; b++) begin
        d = g[b] ? pal_f(p) : 24'h0;
        exp_q.push_back({d, (i == 3 && b == 34)});
      end
    end
    $display("expect frame text=%h colors=%h", txt, col);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [3:0] c, input logic s);
    rx_data   = d;
    rx_color  = c;
    scroll_en = s;
    rx_valid  = 1'b1;
    @(negedge clk);
    rx_valid  = 1'b0;
    $display("rx byte=%h color=%0d scroll=%0b", d, c, s);
  endtask

  task automatic wait_busy(input logic lvl, input int limit, input string name);
    int n = 0;
    while (frame_busy !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_busy !== lvl) begin
      errors++;
      $display("FAIL %s timeout got busy=%b required %b", name, frame_busy, lvl);
    end
  endtask

  task automatic run_frame(input string name, input int left);
    wait_busy(1'b1, 5000, {name, "_start"});
    wait_busy(1'b0, 5000, {name, "_end"});
    chk({name, "_latch_after"}, 32'(px_latch), 32'h0);
    chk({name, "_left"}, 32'(exp_q.size()), 32'(left));
  endtask

  initial begin
    logic quiet;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 32'h0);
    chk("rst_px_valid", 32'(px_valid), 32'h0);
    chk("rst_px_latch", 32'(px_latch), 32'h0);
    chk("rst_busy", 32'(frame_busy), 32'h0);
    chk("rst_px_data", 32'(px_data), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rx_ready_up", 32'(rx_ready), 32'h1);

    push_frame(32'h20202020, 16'h3210);
    run_frame("f_default", 0);

    send_byte("A", 4'd1, 1'b0);
    send_byte("B", 4'd2, 1'b0);
    send_byte("C", 4'd3, 1'b0);
    send_byte("D", 4'd4, 1'b0);
    send_byte("E", 4'd5, 1'b0);
    push_frame(32'h44434245, 16'h4325);
    run_frame("f_wrap", 0);

    send_byte("W", 4'd6, 1'b1);
    send_byte("X", 4'd7, 1'b1);
    send_byte("Y", 4'd8, 1'b1);
    send_byte("Z", 4'd9, 1'b1);
    send_byte("Q", 4'd10, 1'b1);
    push_frame(32'h515A5958, 16'hA987);
    run_frame("f_scroll", 0);

    send_byte("R", 4'd11, 1'b0);
    push_frame(32'h515A5258, 16'hA9B7);
    run_frame("f_ptr_kept", 0);

    send_byte("A", 4'd12, 1'b0);
    send_byte("B", 4'd13, 1'b0);
    send_byte(8'h0C, 4'd0, 1'b0);
    send_byte("K", 4'd14, 1'b0);
    push_frame(32'h2020204B, 16'hDCBE);
    run_frame("f_clear", 0);

    push_frame(32'h2020204B, 16'hDCBE);
    wait_busy(1'b1, 5000, "f_inject_start");
    send_byte("M", 4'd15, 1'b0);
    push_frame(32'h20204D4B, 16'hDCFE);
    wait_busy(1'b0, 5000, "f_inject_end");
    chk("f_inject_left", 32'(exp_q.size()), 32'd140);
    run_frame("f_after_inject", 0);

    hold_low = 1'b1;
    push_frame(32'h20204D4B, 16'hDCFE);
    wait_busy(1'b1, 5000, "f_hold_start");
    repeat (2200) @(negedge clk);
    chk("hold_busy", 32'(frame_busy), 32'h1);
    chk("hold_valid", 32'(px_valid), 32'h0);
    hold_low = 1'b0;
    wait_busy(1'b0, 5000, "f_hold_end");
    chk("f_hold_left", 32'(exp_q.size()), 32'h0);
    quiet = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (frame_busy) quiet = 1'b0;
    end
    chk("no_queued_frame", 32'(quiet), 32'h1);

    push_frame(32'h20204D4B, 16'hDCFE);
    wait_busy(1'b1, 5000, "f_reset_start");
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_px_valid", 32'(px_valid), 32'h0);
    chk("midrst_busy", 32'(frame_busy), 32'h0);
    chk("midrst_px_latch", 32'(px_latch), 32'h0);
    chk("midrst_px_data", 32'(px_data), 32'h0);
    exp_q.delete();
    rst_n = 1'b1;
    push_frame(32'h20202020, 16'h3210);
    run_frame("f_post_reset", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
